// File: rtl/mole_round_sequencer_pkg.sv
// Shared definitions for the whack-a-mole session sequencer.
// Holds the FSM state encoding, default parameter values, mole-word
// geometry and the adjacent-nibble duplicate check used when the
// MOLE_SEQ_NODUP_EN build option is enabled.
package mole_round_sequencer_pkg;

  localparam int CNT_W_DEF       = 7;
  localparam int RND_TIMEOUT_DEF = 1023;
  localparam int NIB_W           = 4;
  localparam int NIB_N           = 8;
  localparam int WORD_W          = NIB_W * NIB_N;

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, PLAY, DONE
  } seq_state_e;

  // True when any two neighbouring mole positions in the word are equal.
  function automatic logic has_adj_dup(input logic [WORD_W-1:0] w);
    logic d;
    d = 1'b0;
    for (int i = 0; i < NIB_N - 1; i++)
      if (w[i*NIB_W +: NIB_W] == w[(i+1)*NIB_W +: NIB_W]) d = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/mole_round_sequencer_if.sv
// Bus between the session sequencer, the random-word source and the
// game datapath.
//   master (sequencer): drives rnd_req, load_en, load_data, game_start;
//                       samples rnd_valid, rnd_data, change_answer,
//                       cur_count, miss, game_end.
//   slave  (source/datapath side): the mirror image.
interface mole_round_sequencer_if
  import mole_round_sequencer_pkg::*;
#(parameter int CNT_W = CNT_W_DEF);

  logic              rnd_req;
  logic              rnd_valid;
  logic [WORD_W-1:0] rnd_data;
  logic              load_en;
  logic [WORD_W-1:0] load_data;
  logic              game_start;
  logic              change_answer;
  logic [CNT_W-1:0]  cur_count;
  logic              miss;
  logic              game_end;

  modport master (
    output rnd_req, load_en, load_data, game_start,
    input  rnd_valid, rnd_data, change_answer, cur_count, miss, game_end
  );

  modport slave (
    input  rnd_req, load_en, load_data, game_start,
    output rnd_valid, rnd_data, change_answer, cur_count, miss, game_end
  );

endinterface

// File: rtl/mole_round_sequencer_tally.sv
// mole_tally: hit/miss tallies for one game session.
// A change of cur_count marks a resolved problem; the miss pulse in that
// same cycle classifies it. Both counters saturate at all-ones.
// Ports: clk, reset (async, active-high), clr (session start: clear
// counters and resample cur_count), en (tally active), cur_count, miss,
// score, miss_count.
module mole_tally #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] cur_count,
  input  logic             miss,
  output logic [CNT_W-1:0] score,
  output logic [CNT_W-1:0] miss_count
);

  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [CNT_W-1:0] prev_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_count <= '0;
      score      <= '0;
      miss_count <= '0;
    end else if (clr) begin
      prev_count <= cur_count;
      score      <= '0;
      miss_count <= '0;
    end else if (en && (cur_count != prev_count)) begin
      prev_count <= cur_count;
      if (miss) begin
        if (miss_count != CMAX) miss_count <= miss_count + 1'b1;
      end else begin
        if (score != CMAX) score <= score + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mole_round_sequencer.sv
// mole_round_sequencer: session controller for the whack-a-mole datapath.
// Fetches mole-position words from the random source, loads them into the
// datapath, fires the one-shot game start and tallies hits/misses.
// Ports: clk, reset (async, active-high), start_btn, bus (master side of
// mole_round_sequencer_if), busy, done, score, miss_count.
// Build option: MOLE_SEQ_NODUP_EN rejects words with equal adjacent nibbles.
module mole_round_sequencer
  import mole_round_sequencer_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int RND_TIMEOUT = RND_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_btn,
  mole_round_sequencer_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      score,
  output logic [CNT_W-1:0]      miss_count
);

  localparam int              TMO_W    = $clog2(RND_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RND_TIMEOUT - 1);

  seq_state_e        state, state_n;
  logic [TMO_W-1:0]  timer, timer_n;
  logic              first, first_n;
  logic [WORD_W-1:0] word;
  logic              rnd_req, req_n;
  logic              load_en, game_start;
  logic              cap, sess_clr, reject;

`ifdef MOLE_SEQ_NODUP_EN
  assign reject = has_adj_dup(bus.rnd_data);
`else
  assign reject = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    first_n  = first;
    req_n    = 1'b0;
    cap      = 1'b0;
    sess_clr = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_btn) begin
          state_n  = FETCH;
          first_n  = 1'b1;
          sess_clr = 1'b1;
          timer_n  = '0;
          req_n    = 1'b1;
        end
      end
      FETCH: begin
        req_n = 1'b1;
        // rnd_req low inside FETCH is the one-cycle retry gap; any
        // rnd_valid seen here is ignored and the request comes back.
        if (rnd_req) begin
          if (bus.rnd_valid) begin
            req_n   = 1'b0;
            timer_n = '0;
            if (!reject) begin
              state_n = LOAD;
              cap     = 1'b1;
            end
          end else if (timer == TMO_LAST) begin
            req_n   = 1'b0;
            timer_n = '0;
          end else begin
            timer_n = timer + TMO_W'(1);
          end
        end
      end
      LOAD:  state_n = first ? START : PLAY;
      START: begin
        state_n = PLAY;
        first_n = 1'b0;
      end
      PLAY: begin
        if (bus.game_end) begin
          state_n = DONE;
        end else if (bus.change_answer) begin
          state_n = FETCH;
          timer_n = '0;
          req_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      first      <= 1'b0;
      word       <= '0;
      rnd_req    <= 1'b0;
      load_en    <= 1'b0;
      game_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      first      <= first_n;
      if (cap) word <= bus.rnd_data;
      rnd_req    <= req_n;
      load_en    <= (state_n == LOAD);
      game_start <= (state_n == START);
      busy       <= (state_n inside {FETCH, LOAD, START, PLAY});
      done       <= (state_n == DONE);
    end
  end

  assign bus.rnd_req    = rnd_req;
  assign bus.load_en    = load_en;
  assign bus.load_data  = word;
  assign bus.game_start = game_start;

  mole_tally #(.CNT_W(CNT_W)) u_tally (
    .clk        (clk),
    .reset      (reset),
    .clr        (sess_clr),
    .en         ((state != IDLE) && (state != DONE)),
    .cur_count  (bus.cur_count),
    .miss       (bus.miss),
    .score      (score),
    .miss_count (miss_count)
  );

endmodule
